// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush control for the five-stage core: RAW hazard detection,
// taken-branch flushes, SRAM wait sequencing and saturating perf counters.
module pipeline_stall_ctrl #(
  parameter int MEM_WAIT_CYCLES = 5,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             forward_en,
  input  logic             ID_valid,
  input  logic [3:0]       ID_src1,
  input  logic [3:0]       ID_src2,
  input  logic             ID_two_src,
  input  logic [3:0]       EXE_dst,
  input  logic             EXE_wb_en,
  input  logic             EXE_mem_read,
  input  logic [3:0]       MEM_dst,
  input  logic             MEM_wb_en,
  input  logic             MEM_mem_req,
  input  logic             mem_ready,
  input  logic             EXE_branch_taken,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_bubble,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_freeze,
  output logic             mem_wb_bubble,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] WAIT_INIT = 8'(MEM_WAIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_freeze;
  logic       exe_hit1, exe_hit2, mem_hit1, mem_hit2;
  logic       hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: if (MEM_mem_req) begin
        wait_cnt_nxt = WAIT_INIT;
        state_nxt    = WAIT;
      end
      WAIT: begin
        wait_cnt_nxt = (wait_cnt == 8'd0) ? 8'd0 : wait_cnt - 8'd1;
        if (wait_cnt == 8'd0 && mem_ready) state_nxt = DONE;
      end
      // The completing instruction is still in MEM, so its request is ignored.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_freeze = rst_n & (((state == IDLE) & MEM_mem_req) | (state == WAIT));

  // With forwarding only a load in EXE can't be bypassed; MEM results always can.
  assign exe_hit1 = EXE_wb_en & (EXE_dst == ID_src1) & (~forward_en | EXE_mem_read);
  assign exe_hit2 = EXE_wb_en & (EXE_dst == ID_src2) & (~forward_en | EXE_mem_read);
  assign mem_hit1 = ~forward_en & MEM_wb_en & (MEM_dst == ID_src1);
  assign mem_hit2 = ~forward_en & MEM_wb_en & (MEM_dst == ID_src2);
  assign hazard   = ID_valid & (exe_hit1 | mem_hit1 | (ID_two_src & (exe_hit2 | mem_hit2)));

  assign pc_freeze      = rst_n & (mem_freeze | (~EXE_branch_taken & hazard));
  assign if_id_freeze   = pc_freeze;
  assign id_exe_bubble  = rst_n & ~mem_freeze & ~EXE_branch_taken & hazard;
  assign if_id_flush    = rst_n & ~mem_freeze & EXE_branch_taken;
  assign id_exe_flush   = if_id_flush;
  assign exe_mem_freeze = mem_freeze;
  assign mem_wb_bubble  = mem_freeze;
  assign mem_busy       = rst_n & (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_freeze && stall_count != '1)   stall_count <= stall_count + CNT_W'(1);
      if (if_id_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: driver predicts each cycle's outputs from a cycle-count
// model of the SRAM access; monitor compares them against the DUT.
module tb_pipeline_stall_ctrl;
  localparam int W    = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst, fwd, idv;
    logic [3:0] s1, s2;
    logic       two;
    logic [3:0] ed;
    logic       ewb, emr;
    logic [3:0] md;
    logic       mwb, req, rdy, br;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic forward_en = 0, ID_valid = 0, ID_two_src = 0, EXE_wb_en = 0, EXE_mem_read = 0;
  logic MEM_wb_en = 0, MEM_mem_req = 0, mem_ready = 0, EXE_branch_taken = 0;
  logic [3:0] ID_src1 = 0, ID_src2 = 0, EXE_dst = 0, MEM_dst = 0;
  logic pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, id_exe_flush;
  logic exe_mem_freeze, mem_wb_bubble, mem_busy;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_stall_ctrl #(.MEM_WAIT_CYCLES(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .forward_en(forward_en), .ID_valid(ID_valid),
    .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .EXE_dst(EXE_dst), .EXE_wb_en(EXE_wb_en), .EXE_mem_read(EXE_mem_read),
    .MEM_dst(MEM_dst), .MEM_wb_en(MEM_wb_en), .MEM_mem_req(MEM_mem_req),
    .mem_ready(mem_ready), .EXE_branch_taken(EXE_branch_taken),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .id_exe_bubble(id_exe_bubble),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_freeze(exe_mem_freeze), .mem_wb_bubble(mem_wb_bubble),
    .mem_busy(mem_busy), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  logic [15:0] expq[$];
  int vectors = 0, miscompares = 0, cyc = 0;

  // Reference model: phase 0 idle, 1 waiting, 2 completing; elapsed counts wait cycles.
  int ph = 0, elapsed = 0, sc = 0, fc = 0;

  function automatic in_t quiet();
    in_t v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic step(input in_t v);
    logic [15:0] e;
    logic hz, frz, pcf, bub, fl;
    logic [3:0] src;
    @(negedge clk);
    rst_n = v.rst; forward_en = v.fwd; ID_valid = v.idv; ID_src1 = v.s1; ID_src2 = v.s2;
    ID_two_src = v.two; EXE_dst = v.ed; EXE_wb_en = v.ewb; EXE_mem_read = v.emr;
    MEM_dst = v.md; MEM_wb_en = v.mwb; MEM_mem_req = v.req; mem_ready = v.rdy;
    EXE_branch_taken = v.br;
    pcf = 0; fl = 0;
    if (!v.rst) begin
      ph = 0; elapsed = 0; sc = 0; fc = 0;
      e = '0;
    end else begin
      hz = 0;
      for (int k = 0; k < 2; k++) begin
        src = (k == 0) ? v.s1 : v.s2;
        if (v.idv && (k == 0 || v.two)) begin
          if (v.ewb && v.ed == src && (!v.fwd || v.emr)) hz = 1;
          if (!v.fwd && v.mwb && v.md == src) hz = 1;
        end
      end
      frz = (ph == 0 && v.req) || ph == 1;
      pcf = frz || (!v.br && hz);
      bub = !frz && !v.br && hz;
      fl  = !frz && v.br;
      e = {pcf, pcf, bub, fl, fl, frz, frz, logic'(ph != 0), 4'(sc), 4'(fc)};
    end
    expq.push_back(e);
    @(posedge clk);
    cyc++;
    if (v.rst) begin
      if (pcf && sc < CMAX) sc++;
      if (fl && fc < CMAX) fc++;
      case (ph)
        0: if (v.req) begin ph = 1; elapsed = 0; end
        1: begin elapsed++; if (elapsed >= W && v.rdy) ph = 2; end
        default: ph = 0;
      endcase
    end
  endtask

  initial begin : monitor
    logic [15:0] e, a;
    forever begin
      @(negedge clk); #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, id_exe_flush,
             exe_mem_freeze, mem_wb_bubble, mem_busy, stall_count, flush_count};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL ctrl cycle %0d: got %h expected %h", cyc, a, e);
        end
      end
    end
  end

  initial begin : driver
    in_t v;
    // Reset with every input high.
    v = '1; v.rst = 1'b0;
    repeat (3) step(v);
    v = quiet(); repeat (2) step(v);
    // Load-use with forwarding.
    v = quiet(); v.fwd = 1; v.idv = 1; v.s1 = 3; v.ed = 3; v.ewb = 1; v.emr = 1; step(v);
    v.emr = 0; step(v);
    v = quiet(); v.idv = 1; v.s1 = 3; v.md = 3; v.mwb = 1; step(v);
    // Second source gated by ID_two_src.
    v = quiet(); v.fwd = 1; v.idv = 1; v.s1 = 1; v.s2 = 7; v.ed = 7; v.ewb = 1; v.emr = 1;
    step(v); v.two = 1; step(v);
    // Branch beats load-use hazard.
    v.br = 1; step(v);
    v = quiet(); step(v);
    // Access with mem_ready high: 6 frozen, 1 DONE.
    v = quiet(); v.req = 1; v.rdy = 1; repeat (7) step(v);
    v = quiet(); repeat (2) step(v);
    // mem_ready low 3 extra cycles at counter zero.
    v = quiet(); v.req = 1; repeat (8) step(v);
    v.rdy = 1; repeat (2) step(v);
    v = quiet(); step(v);
    // Branch arriving during a freeze waits for the release.
    v = quiet(); v.req = 1; v.rdy = 1; v.br = 1; repeat (7) step(v);
    v.req = 0; step(v);
    v = quiet(); step(v);
    // Stall counter saturation.
    v = quiet(); v.idv = 1; v.s1 = 2; v.ed = 2; v.ewb = 1; repeat (20) step(v);
    // Reset pulsed in WAIT.
    v = quiet(); v.req = 1; repeat (3) step(v);
    v.rst = 0; step(v);
    v.rst = 1; v.req = 0; repeat (2) step(v);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      v.rst = ($urandom_range(0, 249) != 0);
      v.fwd = 1'($urandom_range(0, 1)); v.idv = ($urandom_range(0, 3) != 0);
      v.s1 = 4'($urandom_range(0, 3)); v.s2 = 4'($urandom_range(0, 3));
      v.two = 1'($urandom_range(0, 1));
      v.ed = 4'($urandom_range(0, 3)); v.ewb = 1'($urandom_range(0, 1));
      v.emr = 1'($urandom_range(0, 1));
      v.md = 4'($urandom_range(0, 3)); v.mwb = 1'($urandom_range(0, 1));
      v.req = ($urandom_range(0, 3) == 0); v.rdy = 1'($urandom_range(0, 1));
      v.br = ($urandom_range(0, 5) == 0);
      step(v);
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #5;
    if (expq.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
